// File: rtl/reg_file_sb.sv
// Architectural register file x0..x31 with two bypassed combinational read ports
// and a per-register pending-write scoreboard that drives read hazard flags.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_enable_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              issue_i,
   input  logic [ADDR_W-1:0] issue_addr_i,
   output logic              hazard1_o,
   output logic              hazard2_o,
   output logic              sb_ovf_o
);

   localparam int              NREG    = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [DATA_W-1:0] regs [NREG];
   logic [CNT_W-1:0]  cnt  [NREG];
   logic              sb_ovf;

   logic inc_any;
   logic dec_any;
   logic same_reg;
   logic inc_eff;
   logic dec_eff;

   assign inc_any  = issue_i && (issue_addr_i != '0);
   assign dec_any  = w_enable_i && (w_addr_i != '0) && (cnt[w_addr_i] != '0);
   // An issue and a retire on the same register cancel: net occupancy is unchanged.
   assign same_reg = inc_any && dec_any && (issue_addr_i == w_addr_i);
   assign inc_eff  = inc_any && !same_reg;
   assign dec_eff  = dec_any && !same_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         sb_ovf <= 1'b0;
      end else begin
         if (w_enable_i && (w_addr_i != '0)) begin
            regs[w_addr_i] <= w_data_i;
         end
         for (int r = 1; r < NREG; r++) begin
            if (inc_eff && (issue_addr_i == ADDR_W'(r))) begin
               if (cnt[r] != CNT_MAX) begin
                  cnt[r] <= cnt[r] + CNT_ONE;
               end
            end else if (dec_eff && (w_addr_i == ADDR_W'(r))) begin
               cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
         if (inc_eff && (cnt[issue_addr_i] == CNT_MAX)) begin
            sb_ovf <= 1'b1;
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic re,
                                                   input logic [ADDR_W-1:0] a);
      if (!re || (a == '0)) begin
         read_port = '0;
      end else if (w_enable_i && (w_addr_i == a)) begin
         read_port = w_data_i;
      end else begin
         read_port = regs[a];
      end
   endfunction

   // A writeback retiring the only outstanding writer is covered by the bypass.
   function automatic logic hazard_port(input logic re, input logic [ADDR_W-1:0] a);
      hazard_port = re && (a != '0) && (cnt[a] != '0) &&
                    !(w_enable_i && (w_addr_i == a) && (cnt[a] == CNT_ONE));
   endfunction

   assign rdata1_o  = rst ? '0   : read_port(re1_i, raddr1_i);
   assign rdata2_o  = rst ? '0   : read_port(re2_i, raddr2_i);
   assign hazard1_o = rst ? 1'b0 : hazard_port(re1_i, raddr1_i);
   assign hazard2_o = rst ? 1'b0 : hazard_port(re2_i, raddr2_i);
   assign sb_ovf_o  = sb_ovf;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, async-reset sequence and
// randomized traffic against an array-based reference of registers and pending counts.
module tb_reg_file_sb;

   localparam int CNT_MAX = 3;

   logic        clk;
   logic        rst;
   logic        w_enable_i;
   logic [4:0]  w_addr_i;
   logic [31:0] w_data_i;
   logic        re1_i;
   logic [4:0]  raddr1_i;
   logic [31:0] rdata1_o;
   logic        re2_i;
   logic [4:0]  raddr2_i;
   logic [31:0] rdata2_o;
   logic        issue_i;
   logic [4:0]  issue_addr_i;
   logic        hazard1_o;
   logic        hazard2_o;
   logic        sb_ovf_o;

   reg_file_sb dut (
      .clk(clk), .rst(rst),
      .w_enable_i(w_enable_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
      .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
      .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
      .issue_i(issue_i), .issue_addr_i(issue_addr_i),
      .hazard1_o(hazard1_o), .hazard2_o(hazard2_o), .sb_ovf_o(sb_ovf_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   // reference: register contents, outstanding writers, sticky overflow
   logic [31:0] m_regs [32];
   int          m_cnt  [32];
   logic        m_ovf;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        r1;
      logic [4:0]  a1;
      logic        r2;
      logic [4:0]  a2;
      logic        iss;
      logic [4:0]  ia;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        h1;
      logic        h2;
      logic        ovf;
   } vec_t;

   vec_t tbl [28];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
      m_ovf = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
      if (!re || a == 0) return 32'h0;
      if (w_enable_i && w_addr_i == a) return w_data_i;
      return m_regs[a];
   endfunction

   function automatic logic model_hazard(input logic re, input logic [4:0] a);
      if (!re || a == 0 || m_cnt[a] == 0) return 1'b0;
      if (w_enable_i && w_addr_i == a && m_cnt[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   // driver tasks
   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2,
                        input logic iss, input logic [4:0] ia);
      w_enable_i = we; w_addr_i = wa; w_data_i = wd;
      re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
      issue_i = iss; issue_addr_i = ia;
   endtask

   // Clock edge, then advance the reference with the inputs that were applied.
   task automatic commit();
      bit inc, dec;
      @(posedge clk);
      inc = issue_i && issue_addr_i != 0;
      dec = w_enable_i && w_addr_i != 0 && m_cnt[w_addr_i] != 0;
      if (w_enable_i && w_addr_i != 0) m_regs[w_addr_i] = w_data_i;
      if (!(inc && dec && issue_addr_i == w_addr_i)) begin
         if (dec) m_cnt[w_addr_i]--;
         if (inc) begin
            if (m_cnt[issue_addr_i] == CNT_MAX) m_ovf = 1'b1;
            else m_cnt[issue_addr_i]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e;
      exp_q.push_back(model_read(re1_i, raddr1_i));
      exp_q.push_back(model_read(re2_i, raddr2_i));
      e = exp_q.pop_front(); check({tag, "_rdata1"}, rdata1_o, e);
      e = exp_q.pop_front(); check({tag, "_rdata2"}, rdata2_o, e);
      check({tag, "_hazard1"}, 32'(hazard1_o), 32'(model_hazard(re1_i, raddr1_i)));
      check({tag, "_hazard2"}, 32'(hazard2_o), 32'(model_hazard(re2_i, raddr2_i)));
      check({tag, "_ovf"}, 32'(sb_ovf_o), 32'(m_ovf));
   endtask

   initial begin
      tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd0,  1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 5'd0,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  1'b1, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 5'd7,  32'hA5,       1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 5'd0,  32'hA5,       32'hA5,       1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  32'hA5,       32'h0,        1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 5'd9,  32'h11,       1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 5'd0,  32'h11,       32'h0,        1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 5'd0,  32'h11,       32'h0,        1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 5'd9,  32'h22,       1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 5'd0,  32'h22,       32'h0,        1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 5'd0,  32'h22,       32'h0,        1'b0, 1'b0, 1'b0};
      for (int i = 15; i <= 18; i++)
         tbl[i] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 1'b1};
      tbl[20] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  32'h44,       32'h0,        1'b1, 1'b0, 1'b1};
      tbl[21] = '{1'b1, 5'd4,  32'h45,       1'b0, 5'd0,  1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        32'h45,       1'b0, 1'b1, 1'b1};
      tbl[22] = '{1'b1, 5'd4,  32'h46,       1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  32'h46,       32'h0,        1'b0, 1'b0, 1'b1};
      tbl[23] = '{1'b1, 5'd4,  32'h47,       1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  32'h47,       32'h0,        1'b0, 1'b0, 1'b1};
      tbl[24] = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd10, 1'b0, 5'd0,  1'b1, 5'd10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
      tbl[25] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        32'h77,       1'b1, 1'b0, 1'b1};
      tbl[26] = '{1'b1, 5'd10, 32'h10A,      1'b1, 5'd10, 1'b0, 5'd0,  1'b1, 5'd10, 32'h10A,      32'h0,        1'b0, 1'b0, 1'b1};
      tbl[27] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 1'b0, 5'd0,  1'b0, 5'd0,  32'h10A,      32'h0,        1'b1, 1'b0, 1'b1};

      // reset with live inputs: outputs must stay quiet
      rst = 1'b1;
      drive(1'b1, 5'd5, 32'hCAFE0005, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5);
      model_reset();
      #3;
      check("rst_rdata1", rdata1_o, 32'h0);
      check("rst_hazard1", 32'(hazard1_o), 32'h0);
      check("rst_ovf", 32'(sb_ovf_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // directed vector table
      for (int i = 0; i < 28; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].a1,
               tbl[i].r2, tbl[i].a2, tbl[i].iss, tbl[i].ia);
         #2;
         check($sformatf("vec%0d_rdata1", i), rdata1_o, tbl[i].e1);
         check($sformatf("vec%0d_rdata2", i), rdata2_o, tbl[i].e2);
         check($sformatf("vec%0d_hazard1", i), 32'(hazard1_o), 32'(tbl[i].h1));
         check($sformatf("vec%0d_hazard2", i), 32'(hazard2_o), 32'(tbl[i].h2));
         check($sformatf("vec%0d_ovf", i), 32'(sb_ovf_o), 32'(tbl[i].ovf));
         commit();
      end

      // asynchronous reset between edges with x7=0x55 and two writers pending
      drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      commit();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
      commit();
      commit();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
      #2;
      check("pre_rst_rdata1", rdata1_o, 32'h55);
      check("pre_rst_hazard2", 32'(hazard2_o), 32'h1);
      #1;
      rst = 1'b1;
      drive(1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
      #1;
      check("mid_rst_rdata1", rdata1_o, 32'h0);
      check("mid_rst_rdata2", rdata2_o, 32'h0);
      check("mid_rst_hazard1", 32'(hazard1_o), 32'h0);
      check("mid_rst_hazard2", 32'(hazard2_o), 32'h0);
      check("mid_rst_ovf", 32'(sb_ovf_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
      #2;
      check("post_rst_rdata1", rdata1_o, 32'h0);
      check("post_rst_hazard1", 32'(hazard1_o), 32'h0);
      commit();

      // randomized traffic on a small index range to force collisions
      for (int n = 0; n < 400; n++) begin
         logic        we, r1, r2, iss;
         logic [4:0]  wa, a1, a2, ia;
         we  = ($urandom_range(0, 1) == 1);
         wa  = 5'($urandom_range(0, 7));
         r1  = ($urandom_range(0, 3) != 0);
         a1  = 5'($urandom_range(0, 7));
         r2  = ($urandom_range(0, 3) != 0);
         a2  = 5'($urandom_range(0, 7));
         iss = ($urandom_range(0, 9) < 4);
         ia  = 5'($urandom_range(0, 7));
         // leave issue+retire of one saturated register out of the random mix
         if (iss && we && ia == wa && ia != 0 && m_cnt[ia] == CNT_MAX) iss = 1'b0;
         drive(we, wa, $urandom, r1, a1, r2, a2, iss, ia);
         #2;
         check_model($sformatf("rnd%0d", n));
         commit();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
